// File: rtl/pkt_top_k_pkg.sv
// Shared constants and state encoding for the top-k sorter stage.
// Holds the beat geometry (notification/payload/metadata widths, lane count),
// the notification field offsets and the FSM state type.
package pkt_top_k_pkg;

    localparam int NOTIF_W     = 88;
    localparam int DATA_W      = 512;
    localparam int META_W      = 32;
    localparam int LANES       = 16;
    localparam int SESSION_LSB = 512;
    localparam int LENGTH_LSB  = 528;

    typedef enum logic [1:0] {
        IDLE,
        INSERT,
        EMIT
    } state_e;

    // Whole 32-bit elements in a beat of 'len' bytes, capped at the lane count.
    // A trailing partial element is dropped by the >>2.
    function automatic logic [4:0] elem_count(input logic [15:0] len);
        logic [13:0] words;
        words = len[15:2];
        return (words > 14'd16) ? 5'd16 : words[4:0];
    endfunction

endpackage

// File: rtl/sorted_insert_array.sv
// K-entry descending sorted register array with single-cycle insert.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clr_i          empty the array (all slot-valid bits cleared)
//   ins_valid_i    insert ins_data_i this cycle
//   ins_data_i     value to insert (unsigned)
//   slot_data_o    current slot contents, slot 0 = largest
//   slot_vld_o     current slot-valid bits (always a prefix of ones)
//   nxt_data_o     slot contents after this cycle's clear/insert
//   nxt_vld_o      slot-valid bits after this cycle's clear/insert
module sorted_insert_array #(
    parameter int K      = 8,
    parameter int ELEM_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      ins_valid_i,
    input  logic [ELEM_W-1:0]         ins_data_i,
    output logic [K-1:0][ELEM_W-1:0]  slot_data_o,
    output logic [K-1:0]              slot_vld_o,
    output logic [K-1:0][ELEM_W-1:0]  nxt_data_o,
    output logic [K-1:0]              nxt_vld_o
);

    logic [K-1:0][ELEM_W-1:0] data_q, data_d;
    logic [K-1:0]             vld_q, vld_d;
    logic [K-1:0]             keep;

    // Index j of the *_ext vectors refers to slot j-1, with a virtual slot
    // above slot 0 that always "keeps", so slot 0 needs no special case.
    logic [K:0]               keep_ext;
    logic [K:0][ELEM_W-1:0]   data_ext;
    logic [K:0]               vld_ext;

    // A stored entry stays put if it is >= the new value; this places the
    // new value after equal entries so ties keep arrival order.
    for (genvar j = 0; j < K; j++) begin : g_cmp
        assign keep[j] = vld_q[j] && (data_q[j] >= ins_data_i);
    end

    assign keep_ext = {keep, 1'b1};
    assign data_ext = {data_q, {ELEM_W{1'b0}}};
    assign vld_ext  = {vld_q, 1'b0};

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (clr_i) begin
            data_d = '0;
            vld_d  = '0;
        end else if (ins_valid_i) begin
            for (int j = 0; j < K; j++) begin
                if (!keep[j]) begin
                    if (keep_ext[j]) begin
                        // First slot not kept: the new value lands here.
                        data_d[j] = ins_data_i;
                        vld_d[j]  = 1'b1;
                    end else begin
                        // Below the insertion point: shift down by one.
                        data_d[j] = data_ext[j];
                        vld_d[j]  = vld_ext[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign slot_data_o = data_q;
    assign slot_vld_o  = vld_q;
    assign nxt_data_o  = data_d;
    assign nxt_vld_o   = vld_d;

endmodule

// File: rtl/pkt_top_k_sorter.sv
// Top-k sorter stage: takes one receiver beat (notification + 16 x 32-bit
// payload), inserts its valid elements one per cycle into a sorted array and
// emits one sender beat with the K largest elements in descending order.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pkt_rx_TDATA/VALID/READY   input beat {notification, payload}
//   pkt_tx_TDATA/VALID/READY   output beat {length, session, payload}
//   stat_pkt_count      result beats emitted (wraps)
//   stat_drop_count     zero-length beats dropped (wraps)
module pkt_top_k_sorter
    import pkt_top_k_pkg::*;
#(
    parameter int K      = 8,
    parameter int ELEM_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NOTIF_W+DATA_W-1:0]   pkt_rx_TDATA,
    input  logic                        pkt_rx_TVALID,
    output logic                        pkt_rx_TREADY,
    output logic [META_W+DATA_W-1:0]    pkt_tx_TDATA,
    output logic                        pkt_tx_TVALID,
    input  logic                        pkt_tx_TREADY,
    output logic [31:0]                 stat_pkt_count,
    output logic [31:0]                 stat_drop_count
);

    localparam logic [4:0] K_CNT = 5'(K);

    state_e                          state_q, state_d;
    logic [3:0]                      idx_q, idx_d;
    logic [4:0]                      n_q, n_d;
    logic [LANES-1:0][ELEM_W-1:0]    pay_q, pay_d;
    logic [15:0]                     sess_q, sess_d;
    logic                            rx_rdy_q, rx_rdy_d;
    logic                            tx_vld_q, tx_vld_d;
    logic [META_W+DATA_W-1:0]        tx_data_q, tx_data_d;
    logic [31:0]                     pkt_cnt_q, pkt_cnt_d;
    logic [31:0]                     drop_cnt_q, drop_cnt_d;

    logic                            rx_fire, tx_fire;
    logic [4:0]                      rx_n, kept;
    logic                            arr_ins;
    logic [K-1:0][ELEM_W-1:0]        slot_data, nxt_data;
    logic [K-1:0]                    slot_vld, nxt_vld;
    logic [LANES-1:0][ELEM_W-1:0]    emit_pay;

    // Ready is only ever high in IDLE, so it alone qualifies the handshake.
    assign rx_fire = pkt_rx_TVALID & rx_rdy_q;
    assign tx_fire = tx_vld_q & pkt_tx_TREADY;
    assign rx_n    = elem_count(pkt_rx_TDATA[LENGTH_LSB +: 16]);
    assign kept    = (n_q > K_CNT) ? K_CNT : n_q;
    assign arr_ins = (state_q == INSERT);

    sorted_insert_array #(
        .K      (K),
        .ELEM_W (ELEM_W)
    ) u_sort (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (rx_fire),
        .ins_valid_i (arr_ins),
        .ins_data_i  (pay_q[idx_q]),
        .slot_data_o (slot_data),
        .slot_vld_o  (slot_vld),
        .nxt_data_o  (nxt_data),
        .nxt_vld_o   (nxt_vld)
    );

    // The output register loads on the same edge as the last insert, so it
    // is built from the array's next state rather than its current slots.
    for (genvar j = 0; j < LANES; j++) begin : g_emit
        if (j < K) begin : g_slot
            assign emit_pay[j] = nxt_vld[j] ? nxt_data[j] : '0;
        end else begin : g_zero
            assign emit_pay[j] = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        pay_d      = pay_q;
        sess_d     = sess_q;
        tx_vld_d   = tx_vld_q;
        tx_data_d  = tx_data_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    pay_d  = pkt_rx_TDATA[DATA_W-1:0];
                    sess_d = pkt_rx_TDATA[SESSION_LSB +: 16];
                    n_d    = rx_n;
                    idx_d  = '0;
                    if (rx_n == 5'd0) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end else begin
                        state_d = INSERT;
                    end
                end
            end
            INSERT: begin
                idx_d = idx_q + 4'd1;
                if ({1'b0, idx_q} == n_q - 5'd1) begin
                    state_d   = EMIT;
                    tx_vld_d  = 1'b1;
                    tx_data_d = {9'd0, kept, 2'b00, sess_q, emit_pay};
                end
            end
            EMIT: begin
                if (tx_fire) begin
                    state_d   = IDLE;
                    tx_vld_d  = 1'b0;
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        rx_rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            pay_q      <= '0;
            sess_q     <= '0;
            rx_rdy_q   <= 1'b0;
            tx_vld_q   <= 1'b0;
            tx_data_q  <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            pay_q      <= pay_d;
            sess_q     <= sess_d;
            rx_rdy_q   <= rx_rdy_d;
            tx_vld_q   <= tx_vld_d;
            tx_data_q  <= tx_data_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_rx_TREADY   = rx_rdy_q;
    assign pkt_tx_TVALID   = tx_vld_q;
    assign pkt_tx_TDATA    = tx_data_q;
    assign stat_pkt_count  = pkt_cnt_q;
    assign stat_drop_count = drop_cnt_q;

    // Slot outputs of the array are kept for observation; the result path
    // uses the next-state view.
    logic unused_slots;
    assign unused_slots = ^{slot_data, slot_vld};

endmodule
